imm_gen_stage: RTL and testbench

Decode-stage immediate generator and D→X pipeline register. It consumes the 3-bit immediate-format select produced by the decode control logic together with the raw instruction. It reconstructs the 32-bit immediate and presents instruction, PC and immediate to the execute stage through a valid/ready handshake. A 2-entry skid buffer keeps `in_ready` registered, so backpressure from X never forms a combinational path back into decode.

---
 rtl/imm_gen_stage.sv | 140 ++++++++++++++
 tb/tb_imm_gen_stage.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator feeding a two-entry (head + skid) D->X pipeline register.
// in_ready is registered so backpressure from X never reaches decode combinationally.
module imm_gen_stage #(
   parameter int unsigned PC_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [PC_W-1:0] in_pc,
   input  logic [2:0]      in_imm_sel,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_inst,
   output logic [PC_W-1:0] out_pc,
   output logic [31:0]     out_imm
);

   typedef enum logic [2:0] {
      SEL_S     = 3'd0,
      SEL_B     = 3'd1,
      SEL_U     = 3'd2,
      SEL_JUMP  = 3'd3,
      SEL_I     = 3'd4,
      SEL_SHAMT = 3'd5,
      SEL_Z6    = 3'd6,
      SEL_Z7    = 3'd7
   } imm_sel_e;

   typedef struct packed {
      logic [31:0]     inst;
      logic [PC_W-1:0] pc;
      logic [31:0]     imm;
   } entry_t;

   imm_sel_e   sel;
   logic [31:0] imm_c;
   entry_t     in_entry;

   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   logic   head_valid_q, head_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   in_ready_q, in_ready_d;

   logic   accept;
   logic   drain;

   assign sel = imm_sel_e'(in_imm_sel);

   always_comb begin
      imm_c = '0;
      unique case (sel)
         SEL_S:     imm_c = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         SEL_B:     imm_c = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
         SEL_U:     imm_c = {in_inst[31:12], 12'b0};
         // JAL and JALR share a select; opcode bit 3 tells them apart
         SEL_JUMP:  imm_c = in_inst[3]
                         ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0}
                         : {{20{in_inst[31]}}, in_inst[31:20]};
         SEL_I:     imm_c = {{20{in_inst[31]}}, in_inst[31:20]};
         SEL_SHAMT: imm_c = {27'b0, in_inst[24:20]};
         SEL_Z6,
         SEL_Z7:    imm_c = '0;
         default:   imm_c = '0;
      endcase
   end

   always_comb begin
      in_entry.inst = in_inst;
      in_entry.pc   = in_pc;
      in_entry.imm  = imm_c;
   end

   assign accept = in_valid && in_ready_q;
   assign drain  = head_valid_q && out_ready;

   always_comb begin
      head_d       = head_q;
      skid_d       = skid_q;
      head_valid_d = head_valid_q;
      skid_valid_d = skid_valid_q;

      if (flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         if (drain) begin
            if (skid_valid_q) begin
               head_d       = skid_q;
               head_valid_d = 1'b1;
               skid_valid_d = 1'b0;
            end else if (accept) begin
               head_d       = in_entry;
               head_valid_d = 1'b1;
            end else begin
               head_valid_d = 1'b0;
            end
         end else if (!head_valid_q) begin
            if (accept) begin
               head_d       = in_entry;
               head_valid_d = 1'b1;
            end
         end else if (accept) begin
            // head is held, and accept implies the skid is empty
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
         end
      end

      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q       <= '0;
         skid_q       <= '0;
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         head_q       <= head_d;
         skid_q       <= skid_d;
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = head_valid_q;
   assign out_inst  = head_q.inst;
   assign out_pc    = head_q.pc;
   assign out_imm   = head_q.imm;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomised and directed bench for imm_gen_stage against a queue-based reference model.
module tb_imm_gen_stage;

   localparam int unsigned PC_W = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [PC_W-1:0] in_pc;
   logic [2:0]      in_imm_sel;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_inst;
   logic [PC_W-1:0] out_pc;
   logic [31:0]     out_imm;

   int checks   = 0;
   int failures = 0;

   imm_gen_stage #(.PC_W(PC_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .in_imm_sel(in_imm_sel), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm)
   );

   always #5 clk = ~clk;

   // Sign-extend the low w bits of v.
   function automatic logic [31:0] sext(input logic [31:0] v, input int w);
      logic signed [31:0] t;
      t = signed'(v << (32 - w));
      return 32'(t >>> (32 - w));
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
      logic [31:0] f;
      case (s)
         3'd0: begin f = 32'({i[31:25], i[11:7]}); return sext(f, 12); end
         3'd1: begin f = 32'({i[31], i[7], i[30:25], i[11:8]}) << 1; return sext(f, 13); end
         3'd2: return i & 32'hFFFF_F000;
         3'd3: begin
            if (i[3]) begin
               f = 32'({i[31], i[19:12], i[20], i[30:21]}) << 1;
               return sext(f, 21);
            end
            return sext(i >> 20, 12);
         end
         3'd4: return sext(i >> 20, 12);
         3'd5: return (i >> 20) & 32'd31;
         default: return 32'd0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_inst = '0; in_pc = '0; in_imm_sel = '0;
      flush = 1'b0; out_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_pc !== '0 || out_imm !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs: valid=%0b inst=%h pc=%h imm=%h want 0/0/0/0",
                  out_valid, out_inst, out_pc, out_imm);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_ready_low: got %0b want 0", in_ready);
      end
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready_high: got %0b want 1", in_ready);
      end
   endtask

   task automatic test_formats();
      logic [31:0] insts [7] = '{32'hFE20AE23, 32'hFE000CE3, 32'h123450B7, 32'h001000EF,
                                 32'hFFF100E7, 32'h41F15093, 32'hDEADBEEF};
      logic [2:0]  sels  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd5, 3'd6};
      logic [31:0] exps  [7] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800,
                                 32'hFFFFFFFF, 32'h0000001F, 32'h00000000};
      do_reset();
      tick();
      out_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1; in_inst = insts[k]; in_imm_sel = sels[k]; in_pc = 32'(k * 4);
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_imm !== exps[k] || out_inst !== insts[k]
             || out_pc !== 32'(k * 4)) begin
            failures++;
            $display("FAIL format_%0d: valid=%0b imm=%h inst=%h pc=%h want imm=%h inst=%h",
                     k, out_valid, out_imm, out_inst, out_pc, exps[k], insts[k]);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL format_drained: out_valid=%0b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] got [$];
      int idx;
      logic [31:0] held_imm;
      do_reset();
      tick();
      in_valid = 1'b1; in_inst = 32'h00500093; in_imm_sel = 3'd4; in_pc = 32'h0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_first: valid=%0b pc=%h in_ready=%0b want 1/0/1", out_valid, out_pc, in_ready);
      end
      held_imm = out_imm;
      in_pc = 32'h4; in_inst = 32'h00A00113;
      tick();
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_in_ready_drop: got %0b want 0", in_ready);
      end
      in_pc = 32'h8; in_inst = 32'h00F00193;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_imm !== held_imm || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall_%0d: valid=%0b pc=%h imm=%h in_ready=%0b want 1/0/%h/0",
                     c, out_valid, out_pc, out_imm, in_ready, held_imm);
         end
      end
      out_ready = 1'b1;
      idx = 2;
      for (int c = 0; c < 12; c++) begin
         in_valid = (idx < 4);
         in_pc    = 32'(idx * 4);
         if (out_valid && out_ready) got.push_back(out_pc);
         if (in_valid && in_ready) idx++;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (got.size() != 4 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8 || got[3] !== 32'hC) begin
         failures++;
         $display("FAIL bp_order: got %0d entries %p want 0,4,8,c", got.size(), got);
      end
   endtask

   task automatic fill_two();
      out_ready = 1'b0;
      in_valid = 1'b1; in_imm_sel = 3'd2;
      in_inst = 32'hAAAAA037; in_pc = 32'h40;
      tick();
      in_inst = 32'hBBBBB037; in_pc = 32'h44;
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      tick();
      fill_two();
      flush = 1'b1; in_inst = 32'hCCCCC037; in_pc = 32'h100;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_state: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_ghost_%0d: out_valid=%0b pc=%h want 0", c, out_valid, out_pc);
         end
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      tick();
      fill_two();
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_imm !== 32'd0) begin
         failures++;
         $display("FAIL midreset_out: valid=%0b imm=%h want 0/0", out_valid, out_imm);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_ready: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
      end
   endtask

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] imm;
   } exp_t;

   task automatic test_random();
      exp_t q [$];
      exp_t e;
      int outstanding;
      int errs;
      logic acc, drn;
      do_reset();
      tick();
      outstanding = 0;
      errs = 0;
      for (int c = 0; c < 10000; c++) begin
         in_valid   = ($urandom_range(0, 99) < 60);
         out_ready  = ($urandom_range(0, 99) < 55);
         flush      = ($urandom_range(0, 99) < 2);
         in_inst    = $urandom;
         in_imm_sel = 3'($urandom_range(0, 7));
         in_pc      = $urandom;
         #1;
         checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
            failures++;
            if (errs++ < 10)
               $display("FAIL rand_flags cyc %0d: out_valid=%0b in_ready=%0b want %0b/%0b",
                        c, out_valid, in_ready, q.size() > 0, q.size() < 2);
         end
         if (q.size() > 0) begin
            checks++;
            if (out_inst !== q[0].inst || out_pc !== q[0].pc || out_imm !== q[0].imm) begin
               failures++;
               if (errs++ < 10)
                  $display("FAIL rand_data cyc %0d: inst=%h pc=%h imm=%h want %h/%h/%h",
                           c, out_inst, out_pc, out_imm, q[0].inst, q[0].pc, q[0].imm);
            end
         end
         acc = in_valid && (q.size() < 2);
         drn = out_ready && (q.size() > 0);
         if (in_valid && in_ready) outstanding++;
         if (out_valid && out_ready && outstanding > 0) outstanding--;
         if (flush) outstanding = 0;
         checks++;
         if (outstanding > 2) begin
            failures++;
            if (errs++ < 10)
               $display("FAIL rand_outstanding cyc %0d: got %0d want <=2", c, outstanding);
         end
         if (flush) q.delete();
         else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
               e.inst = in_inst; e.pc = in_pc; e.imm = ref_imm(in_inst, in_imm_sel);
               q.push_back(e);
            end
         end
         @(posedge clk);
         #1;
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_formats();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
